// File: rtl/sys_seq_pkg.sv
// Shared types and constants for the board bring-up sequencer.
// Optional lock recovery in the top is selected with SYS_SEQ_LOCK_RECOVERY_EN.
package sys_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_PLL_WAIT = 3'd1,
        ST_QUALIFY  = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAULT    = 3'd4
    } sys_seq_state_t;

    // Depth of every asynchronous-input synchroniser in the sequencer.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sys_seq_debounce.sv
// Single switch channel: input synchroniser, stability counter and accepted value.
// accepted_next exposes the value the channel will hold after this edge.
module sys_seq_debounce
    import sys_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic accepted_next
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   accepted_reg;
    logic                   sw_s;

    assign sw_s = sync_reg[SYNC_STAGES-1];

    // The counter only advances while the synced input disagrees with the
    // accepted value, so any shorter disagreement is forgotten.
    always_comb begin
        cnt_next      = '0;
        accepted_next = accepted_reg;
        if (sw_s != accepted_reg) begin
            if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                accepted_next = ~accepted_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg     <= '0;
            cnt_reg      <= '0;
            accepted_reg <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], sw_raw};
            cnt_reg      <= cnt_next;
            accepted_reg <= accepted_next;
        end
    end

endmodule

// File: rtl/sys_seq_ctrl.sv
// Board bring-up sequencer: PLL reset hold, lock qualification, gated switch power.
// Define SYS_SEQ_LOCK_RECOVERY_EN to re-sequence after a lock loss instead of latching FAULT.
module sys_seq_ctrl
    import sys_seq_pkg::*;
#(
    parameter int RESET_CYCLES       = 15,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int DEBOUNCE_CYCLES    = 65536,
    parameter int N_SW               = 1,
    parameter int HB_BIT             = 24,
    parameter int FAULT_W            = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic [N_SW-1:0]    sw,
    input  logic               ctrl_ready,
    output logic               pll_reset,
    output logic               sys_resetn,
    output logic [N_SW-1:0]    power,
    output logic [2:0]         state,
    output logic               ready_s,
    output logic [FAULT_W-1:0] fault_cnt,
    output logic               heartbeat
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int QUAL_W = $clog2(LOCK_STABLE_CYCLES + 1);

    sys_seq_state_t         state_reg;
    logic [HOLD_W-1:0]      hold_cnt_reg;
    logic [QUAL_W-1:0]      qual_cnt_reg;
    logic                   pll_reset_reg;
    logic                   sys_resetn_reg;
    logic [N_SW-1:0]        power_reg;
    logic [FAULT_W-1:0]     fault_cnt_reg;
    logic [HB_BIT:0]        hb_cnt_reg;
    logic [SYNC_STAGES-1:0] lock_sync_reg;
    logic [SYNC_STAGES-1:0] ready_sync_reg;
    logic [N_SW-1:0]        sw_accepted_next;
    logic                   lock_s;

    assign lock_s = lock_sync_reg[SYNC_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_deb
            sys_seq_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk          (clk),
                .reset        (reset),
                .sw_raw       (sw[gi]),
                .accepted_next(sw_accepted_next[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_sync_reg  <= '0;
            ready_sync_reg <= '0;
            hb_cnt_reg     <= '0;
        end else begin
            lock_sync_reg  <= {lock_sync_reg[SYNC_STAGES-2:0], pll_locked};
            ready_sync_reg <= {ready_sync_reg[SYNC_STAGES-2:0], ctrl_ready};
            hb_cnt_reg     <= hb_cnt_reg + 1'b1;
        end
    end

    // Outputs are assigned together with the transition that causes them, so
    // each registered output already reflects the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_HOLD;
            hold_cnt_reg   <= '0;
            qual_cnt_reg   <= '0;
            pll_reset_reg  <= 1'b1;
            sys_resetn_reg <= 1'b0;
            power_reg      <= '0;
            fault_cnt_reg  <= '0;
        end else begin
            sys_resetn_reg <= 1'b0;
            power_reg      <= '0;
            case (state_reg)
                ST_HOLD: begin
                    pll_reset_reg <= 1'b1;
                    if (hold_cnt_reg == HOLD_W'(RESET_CYCLES - 1)) begin
                        state_reg     <= ST_PLL_WAIT;
                        pll_reset_reg <= 1'b0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                ST_PLL_WAIT: begin
                    pll_reset_reg <= 1'b0;
                    if (lock_s) begin
                        state_reg    <= ST_QUALIFY;
                        qual_cnt_reg <= '0;
                    end
                end
                ST_QUALIFY: begin
                    pll_reset_reg <= 1'b0;
                    // A drop on the completing cycle must still abort qualification.
                    if (!lock_s) begin
                        state_reg <= ST_PLL_WAIT;
                    end else if (qual_cnt_reg == QUAL_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_reg      <= ST_RUN;
                        sys_resetn_reg <= 1'b1;
                        power_reg      <= sw_accepted_next;
                    end else begin
                        qual_cnt_reg <= qual_cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_reg     <= ST_FAULT;
                        pll_reset_reg <= 1'b1;
                        if (fault_cnt_reg != '1) begin
                            fault_cnt_reg <= fault_cnt_reg + 1'b1;
                        end
                    end else begin
                        pll_reset_reg  <= 1'b0;
                        sys_resetn_reg <= 1'b1;
                        power_reg      <= sw_accepted_next;
                    end
                end
                ST_FAULT: begin
                    pll_reset_reg <= 1'b1;
`ifdef SYS_SEQ_LOCK_RECOVERY_EN
                    state_reg    <= ST_HOLD;
                    hold_cnt_reg <= '0;
`endif
                end
                default: begin
                    state_reg     <= ST_HOLD;
                    hold_cnt_reg  <= '0;
                    pll_reset_reg <= 1'b1;
                end
            endcase
        end
    end

    assign pll_reset  = pll_reset_reg;
    assign sys_resetn = sys_resetn_reg;
    assign power      = power_reg;
    assign state      = state_reg;
    assign ready_s    = ready_sync_reg[SYNC_STAGES-1];
    assign fault_cnt  = fault_cnt_reg;
    assign heartbeat  = hb_cnt_reg[HB_BIT];

endmodule

// File: tb/tb_sys_seq_ctrl.sv
// Bench for sys_seq_ctrl: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed cycle expectations.
module tb_sys_seq_ctrl;

    localparam int R    = 4;
    localparam int L    = 8;
    localparam int D    = 4;
    localparam int NSW  = 2;
    localparam int HB   = 3;
    localparam int FW   = 2;
    localparam int FMAX = (1 << FW) - 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           pll_locked = 1'b1;
    logic [NSW-1:0] sw = '0;
    logic           ctrl_ready = 1'b1;
    logic           pll_reset;
    logic           sys_resetn;
    logic [NSW-1:0] power;
    logic [2:0]     state;
    logic           ready_s;
    logic [FW-1:0]  fault_cnt;
    logic           heartbeat;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    sys_seq_ctrl #(
        .RESET_CYCLES(R), .LOCK_STABLE_CYCLES(L), .DEBOUNCE_CYCLES(D),
        .N_SW(NSW), .HB_BIT(HB), .FAULT_W(FW)
    ) dut (
        .clk(clk), .reset(reset), .pll_locked(pll_locked), .sw(sw),
        .ctrl_ready(ctrl_ready), .pll_reset(pll_reset), .sys_resetn(sys_resetn),
        .power(power), .state(state), .ready_s(ready_s),
        .fault_cnt(fault_cnt), .heartbeat(heartbeat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp, input bit verbose);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end else if (verbose) begin
            $display("check %s ok: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Reference model: states are timestamped on entry; inputs are seen two edges late.
    bit             model_valid = 1'b0;
    int             m_k, m_state, m_enter, m_fault;
    logic           m_lock_q[$];
    logic           m_rdy_q[$];
    logic [NSW-1:0] m_sw_q[$];
    logic [NSW-1:0] m_seen[$];
    logic [NSW-1:0] m_acc, m_power;
    int             m_last_flip[NSW];

    always @(posedge clk) begin : m_step
        logic           lk;
        logic [NSW-1:0] seen;
        bit             all_diff;
        if (reset) begin
            model_valid = 1'b1;
            m_k = 0; m_state = 0; m_enter = 0; m_fault = 0;
            m_acc = '0; m_power = '0;
            m_lock_q = '{1'b0, 1'b0};
            m_rdy_q  = '{1'b0, 1'b0};
            m_sw_q   = '{'0, '0};
            m_seen.delete();
            for (int i = 0; i < NSW; i++) m_last_flip[i] = 0;
        end else if (model_valid) begin
            m_k++;
            lk   = m_lock_q.pop_front(); m_lock_q.push_back(pll_locked);
            seen = m_sw_q.pop_front();   m_sw_q.push_back(sw);
            void'(m_rdy_q.pop_front());  m_rdy_q.push_back(ctrl_ready);
            m_seen.push_back(seen);
            if (m_seen.size() > D) void'(m_seen.pop_front());
            // A switch flips once the last D seen values all differ from it.
            for (int i = 0; i < NSW; i++) begin
                if (m_k - m_last_flip[i] >= D) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < m_seen.size(); j++)
                        if (m_seen[j][i] == m_acc[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_acc[i] = ~m_acc[i];
                        m_last_flip[i] = m_k;
                    end
                end
            end
            case (m_state)
                0: if (m_k - m_enter == R) begin m_state = 1; m_enter = m_k; end
                1: if (lk) begin m_state = 2; m_enter = m_k; end
                2: if (!lk) begin m_state = 1; m_enter = m_k; end
                   else if (m_k - m_enter == L) begin m_state = 3; m_enter = m_k; end
                3: if (!lk) begin
                       m_state = 4; m_enter = m_k;
                       if (m_fault < FMAX) m_fault++;
                   end
                default: begin
`ifdef SYS_SEQ_LOCK_RECOVERY_EN
                    m_state = 0; m_enter = m_k;
`endif
                end
            endcase
            m_power = (m_state == 3) ? m_acc : '0;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("state",      state,      m_state, 1'b0);
            chk("pll_reset",  pll_reset,  int'(m_state == 0 || m_state == 4), 1'b0);
            chk("sys_resetn", sys_resetn, int'(m_state == 3), 1'b0);
            chk("power",      power,      m_power, 1'b0);
            chk("ready_s",    ready_s,    m_rdy_q[0], 1'b0);
            chk("fault_cnt",  fault_cnt,  m_fault, 1'b0);
            chk("heartbeat",  heartbeat,  (m_k >> HB) & 1, 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        int n = 0;
        while (state != target && n < budget) begin
            step();
            n++;
        end
        chk(name, state, target, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"},      state,      0, 1'b1);
        chk({tag, "_pll_reset"},  pll_reset,  1, 1'b1);
        chk({tag, "_sys_resetn"}, sys_resetn, 0, 1'b1);
        chk({tag, "_power"},      power,      0, 1'b1);
        chk({tag, "_fault_cnt"},  fault_cnt,  0, 1'b1);
        chk({tag, "_heartbeat"},  heartbeat,  0, 1'b1);
        chk({tag, "_ready_s"},    ready_s,    0, 1'b1);
    endtask

    initial begin
        int first_lo, first_run, q, r, f;

        // Lock high from the start: synchronisers settle during HOLD, so RUN follows
        // HOLD(4) + PLL_WAIT(1) + QUALIFY(8) = edge 13.
        reset = 1'b1; pll_locked = 1'b1; sw = '0; ctrl_ready = 1'b1;
        step(); step();
        check_reset_values("rst0");
        reset = 1'b0; cyc = 0;
        first_lo = -1; first_run = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (first_lo < 0 && !pll_reset) first_lo = cyc;
            if (first_run < 0 && state == 3) first_run = cyc;
        end
        chk("hold_len", first_lo, 4, 1'b1);
        chk("run_edge", first_run, 13, 1'b1);
        chk("run_resetn", sys_resetn, 1, 1'b1);

        // Lock glitch at qualify count 5: back to PLL_WAIT, fresh window needed.
        pll_locked = 1'b0; reset = 1'b1; step(); reset = 1'b0; cyc = 0;
        wait_state(1, 20, "reach_pll_wait");
        pll_locked = 1'b1;
        wait_state(2, 20, "reach_qualify");
        q = cyc;
        step(); step(); step();
        pll_locked = 1'b0; step();
        pll_locked = 1'b1; step();
        chk("qual_before_drop", state, 2, 1'b1);
        step();
        chk("qual_drop", state, 1, 1'b1);
        wait_state(3, 30, "reach_run_after_drop");
        chk("qual_rerun_delay", cyc - q, 15, 1'b1);

        // Switch held: power follows after 2 + D = 6 edges; 3-cycle pulse is rejected.
        r = cyc;
        sw = 2'b01;
        repeat (5) step();
        chk("sw_before", power, 0, 1'b1);
        step();
        chk("sw_after6", power, 1, 1'b1);
        chk("sw_delay", cyc - r, 6, 1'b1);
        sw = 2'b11;
        repeat (3) step();
        sw = 2'b01;
        repeat (8) step();
        chk("glitch_reject", power, 1, 1'b1);

        // Lock loss in RUN: FSM sees it two edges after the sample edge.
        f = cyc;
        pll_locked = 1'b0;
        step(); step();
        chk("loss_pre_power", power, 1, 1'b1);
        step();
        chk("loss_power", power, 0, 1'b1);
        chk("loss_state", state, 4, 1'b1);
        chk("loss_fault_cnt", fault_cnt, 1, 1'b1);
        pll_locked = 1'b1;
`ifdef SYS_SEQ_LOCK_RECOVERY_EN
        step();
        chk("recover_hold", state, 0, 1'b1);
        wait_state(3, 40, "recover_run");
        for (int n = 0; n < 4; n++) begin
            pll_locked = 1'b0;
            wait_state(4, 10, "loss_again");
            pll_locked = 1'b1;
            wait_state(3, 40, "recover_again");
        end
        chk("fault_saturate", fault_cnt, 3, 1'b1);
`else
        repeat (40) step();
        chk("fault_sticky", state, 4, 1'b1);
        chk("fault_pll_reset", pll_reset, 1, 1'b1);
        reset = 1'b1; step(); reset = 1'b0; cyc = 0;
        wait_state(3, 30, "run_after_reset");
`endif

        // Reset during RUN with both channels powered.
        sw = 2'b11;
        repeat (8) step();
        chk("pre_reset_power", power, 3, 1'b1);
        reset = 1'b1;
        step();
        check_reset_values("rst_run");
        reset = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
